// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master controller.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } state_t;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int edge_cnt_w(input int dwidth);
    return $clog2(2 * dwidth) + 1;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK generator: half-period countdown plus edge counter.
// Strobes fire in the cycle whose closing clk edge moves sclk (or ends the trail).
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 accept,
  input  logic                 active,
  input  logic                 cpol,
  input  logic [DIV_WIDTH-1:0] clk_div,
  output logic                 lead_stb,
  output logic                 trail_stb,
  output logic                 end_stb,
  output logic                 first_edge,
  output logic                 last_edge,
  output logic                 sclk
);

  localparam int EW = edge_cnt_w(DWIDTH);
  localparam logic [EW-1:0] NEDGE = EW'(2 * DWIDTH);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_l;
  logic [EW-1:0]        ecnt;
  logic                 tick;
  logic                 in_xfer;

  assign tick       = active && (cnt == '0);
  assign in_xfer    = (ecnt != NEDGE);
  assign lead_stb   = tick && in_xfer && !ecnt[0];
  assign trail_stb  = tick && in_xfer && ecnt[0];
  assign end_stb    = tick && !in_xfer;
  assign first_edge = (ecnt == '0);
  assign last_edge  = (ecnt == NEDGE - 1'b1);

  always_ff @(posedge clk) begin
    if (accept) div_l <= clk_div;
  end

  // Once all edges are issued, one more half-period elapses as the trail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      ecnt <= '0;
      sclk <= 1'b0;
    end else if (accept) begin
      cnt  <= clk_div;
      ecnt <= '0;
      sclk <= cpol;
    end else if (active) begin
      if (tick) begin
        cnt <= div_l;
        if (in_xfer) begin
          ecnt <= ecnt + 1'b1;
          sclk <= ~sclk;
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else begin
      sclk <= cpol;
    end
  end

endmodule

// File: rtl/spi_master_ctl.sv
// SPI master controller: runtime CPOL/CPHA, clock divider, word width, chip selects.
// Optional SPI_LSB_FIRST_EN adds a lsb_first input selecting LSB-first shifting.
module spi_master_ctl
  import spi_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int DIV_WIDTH = 8,
  parameter int NUM_CS    = 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic                                       cpol,
  input  logic                                       cpha,
`ifdef SPI_LSB_FIRST_EN
  input  logic                                       lsb_first,
`endif
  input  logic [DIV_WIDTH-1:0]                       clk_div,
  input  logic [(NUM_CS > 1 ? $clog2(NUM_CS) : 1)-1:0] cs_sel,
  input  logic [DWIDTH-1:0]                          din,
  output logic [DWIDTH-1:0]                          dout,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       sclk,
  output logic                                       mosi,
  input  logic                                       miso,
  output logic [NUM_CS-1:0]                          cs_n
);

  localparam int CSW = NUM_CS > 1 ? $clog2(NUM_CS) : 1;

  state_t            state;
  logic              accept;
  logic              lead_stb, trail_stb, end_stb, first_edge, last_edge;
  logic              lsb_in, lsb_l, cpha_l;
  logic              shift_en, sample_en;
  logic [DWIDTH-1:0] tx_sr, rx_sr;

  // Out-of-range selects decode to no active line
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CSW-1:0] sel);
    cs_decode = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (CSW'(i) == sel) cs_decode[i] = 1'b0;
    end
  endfunction

  function automatic logic first_bit(input logic [DWIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DWIDTH-1];
  endfunction

  function automatic logic next_bit(input logic [DWIDTH-1:0] sr, input logic lsb);
    return lsb ? sr[1] : sr[DWIDTH-2];
  endfunction

  function automatic logic [DWIDTH-1:0] shift_word(input logic [DWIDTH-1:0] sr,
                                                   input logic lsb);
    return lsb ? (sr >> 1) : (sr << 1);
  endfunction

  function automatic logic [DWIDTH-1:0] capture(input logic [DWIDTH-1:0] sr,
                                                input logic b, input logic lsb);
    return lsb ? {b, sr[DWIDTH-1:1]} : {sr[DWIDTH-2:0], b};
  endfunction

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
  always_ff @(posedge clk) begin
    if (accept) lsb_l <= lsb_first;
  end
`else
  assign lsb_in = 1'b0;
  assign lsb_l  = 1'b0;
`endif

  assign accept    = (state == IDLE) && start;
  // First leading (cpha=1) or last trailing (cpha=0) edge has no bit to shift
  assign shift_en  = cpha_l ? (lead_stb && !first_edge) : (trail_stb && !last_edge);
  assign sample_en = cpha_l ? trail_stb : lead_stb;

  spi_clkgen #(
    .DWIDTH    (DWIDTH),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clkgen (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept     (accept),
    .active     (state != IDLE),
    .cpol       (cpol),
    .clk_div    (clk_div),
    .lead_stb   (lead_stb),
    .trail_stb  (trail_stb),
    .end_stb    (end_stb),
    .first_edge (first_edge),
    .last_edge  (last_edge),
    .sclk       (sclk)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      tx_sr  <= din;
      cpha_l <= cpha;
    end else begin
      if (shift_en)  tx_sr <= shift_word(tx_sr, lsb_l);
      if (sample_en) rx_sr <= capture(rx_sr, miso, lsb_l);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      dout  <= '0;
      mosi  <= 1'b0;
      cs_n  <= '1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LEAD;
            busy  <= 1'b1;
            cs_n  <= cs_decode(cs_sel);
            mosi  <= first_bit(din, lsb_in);
          end
        end
        LEAD: begin
          if (lead_stb) state <= XFER;
        end
        XFER: begin
          if (trail_stb && last_edge) state <= TRAIL;
        end
        TRAIL: begin
          if (end_stb) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cs_n  <= '1;
            dout  <= rx_sr;
          end
        end
        default: state <= IDLE;
      endcase
      if (shift_en) mosi <= next_bit(tx_sr, lsb_l);
    end
  end

endmodule

// File: tb/tb_spi_master_ctl.sv
// Self-checking bench for spi_master_ctl with a behavioural SPI slave model.
module tb_spi_master_ctl;

  logic       clk = 1'b0;
  logic       rst_n, start, cpol, cpha, miso;
  logic [7:0] clk_div, din, dout;
  logic [1:0] cs_sel;
  logic       busy, done, sclk, mosi;
  logic [2:0] cs_n;

  int npass  = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  spi_master_ctl #(
    .DWIDTH    (8),
    .DIV_WIDTH (8),
    .NUM_CS    (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .cpol    (cpol),
    .cpha    (cpha),
    .clk_div (clk_div),
    .cs_sel  (cs_sel),
    .din     (din),
    .dout    (dout),
    .busy    (busy),
    .done    (done),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .cs_n    (cs_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One word: the slave shifts sw out MSB first and collects mosi on its sample edges.
  task automatic xfer(input string tag, input logic [1:0] mode, input logic [7:0] div,
                      input logic [7:0] wd, input logic [7:0] sw, input logic [1:0] sel,
                      input bit loop, input int stray_at, input int abort_edge);
    int         exp_done, edges, rises, k, ndone, done_cyc, mosi_bad, cs_bad;
    logic [7:0] rx, dout_seen;
    logic [2:0] exp_cs, cs_at_done;
    logic       prev_sclk, prev_mosi, busy_at_done, lead, edge_now, shift_edge;
    exp_done = 1 + 17 * (int'(div) + 1);
    exp_cs = 3'b111;
    if (sel < 2'd3) exp_cs[sel] = 1'b0;
    edges = 0; rises = 0; k = 0; ndone = 0; done_cyc = 0; mosi_bad = 0; cs_bad = 0;
    rx = '0; dout_seen = '0; cs_at_done = '0; busy_at_done = 1'b1;
    @(negedge clk);
    cpol = mode[1]; cpha = mode[0]; clk_div = div; cs_sel = sel; din = wd; start = 1'b1;
    if (!mode[0]) begin
      miso = sw[7];
      k = 1;
    end
    prev_sclk = mode[1];
    prev_mosi = mosi;
    for (int c = 1; c <= exp_done + 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        check({tag, "/busy_start"}, busy, 1);
        check({tag, "/cs_start"}, cs_n, exp_cs);
        check({tag, "/sclk_idle"}, sclk, mode[1]);
        check({tag, "/mosi_first"}, mosi, wd[7]);
      end
      if (c == stray_at) begin
        din = 8'hFF;
        start = 1'b1;
      end else if (c == stray_at + 1) begin
        din = wd;
        start = 1'b0;
      end
      edge_now = (sclk !== prev_sclk);
      shift_edge = 1'b0;
      if (edge_now) begin
        edges++;
        lead = edges[0];
        if (sclk) rises++;
        if (lead != mode[0]) begin
          rx = {rx[6:0], mosi};
        end else begin
          shift_edge = 1'b1;
          if (!loop && k < 8) begin
            miso = sw[7-k];
            k++;
          end
        end
        prev_sclk = sclk;
        if (edges == abort_edge) begin
          rst_n = 1'b0;
          #1;
          check({tag, "/abort_cs"}, cs_n, 3'b111);
          check({tag, "/abort_sclk"}, sclk, 0);
          check({tag, "/abort_busy"}, busy, 0);
          check({tag, "/abort_done"}, done, 0);
          @(negedge clk);
          check({tag, "/abort_no_done"}, done, 0);
          rst_n = 1'b1;
          return;
        end
      end
      if (c > 1 && mosi !== prev_mosi && !shift_edge) mosi_bad++;
      prev_mosi = mosi;
      if (loop) miso = mosi;
      if (busy && cs_n !== exp_cs) cs_bad++;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          done_cyc = c;
          dout_seen = dout;
          busy_at_done = busy;
          cs_at_done = cs_n;
        end
      end
    end
    check({tag, "/done_count"}, ndone, 1);
    check({tag, "/done_time"}, done_cyc, exp_done);
    check({tag, "/dout"}, dout_seen, loop ? wd : sw);
    check({tag, "/slave_rx"}, rx, wd);
    check({tag, "/edges"}, edges, 16);
    check({tag, "/rises"}, rises, 8);
    check({tag, "/mosi_timing"}, mosi_bad, 0);
    check({tag, "/cs_hold"}, cs_bad, 0);
    check({tag, "/cs_end"}, cs_at_done, 3'b111);
    check({tag, "/busy_end"}, busy_at_done, 0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0;
    clk_div = '0; cs_sel = '0; din = '0; miso = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/dout", dout, 0);
    check("rst/sclk", sclk, 0);
    check("rst/mosi", mosi, 0);
    check("rst/cs_n", cs_n, 3'b111);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    cpol = 1'b1;
    @(negedge clk);
    check("idle/sclk_hi", sclk, 1);
    cpol = 1'b0;
    @(negedge clk);
    check("idle/sclk_lo", sclk, 0);

    xfer("m0_loop", 2'b00, 8'd0, 8'hA5, 8'h00, 2'd0, 1'b1, 0, 0);
    xfer("m3", 2'b11, 8'd3, 8'h3C, 8'hC3, 2'd1, 1'b0, 0, 0);
    xfer("m1", 2'b01, 8'($urandom_range(2)), 8'h81, 8'($urandom), 2'd0, 1'b0, 0, 0);
    xfer("m2", 2'b10, 8'($urandom_range(2)), 8'h81, 8'($urandom), 2'd0, 1'b0, 0, 0);
    xfer("stray", 2'b00, 8'd1, 8'($urandom), 8'($urandom), 2'd0, 1'b0, 10, 0);
    xfer("abort", 2'b00, 8'd0, 8'($urandom), 8'($urandom), 2'd0, 1'b0, 0, 5);
    xfer("post_rst", 2'b00, 8'd0, 8'h5A, 8'($urandom), 2'd0, 1'b0, 0, 0);
    xfer("cs2", 2'($urandom), 8'd0, 8'($urandom), 8'($urandom), 2'd2, 1'b0, 0, 0);
    xfer("cs3", 2'($urandom), 8'd0, 8'($urandom), 8'($urandom), 2'd3, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      xfer("rand", 2'($urandom), 8'($urandom_range(3)), 8'($urandom), 8'($urandom),
           2'($urandom_range(2)), 1'b0, 0, 0);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
